reg_bus_arbiter: RTL and testbench
==================================

# reg_bus_arbiter

Two-master arbiter for the shared 8-bit register bus (address, bytecnt, data, read/write strobes, addrvalid) fed to all `reg_*` slave blocks. Master 0 is the USB host interface path; master 1 is an on-FPGA sequencer that must reprogram slaves (clock divider, glitch, trigger) without host round-trips. The block grants the bus to one master per burst with round-robin fairness, registers the bus drive, and routes read data back to the owner. A hold-timeout recovers the bus from a stalled master.

## Interface
Parameters:
- ADDR_W, 6, register address width
- BCNT_W, 16, byte-count width
- TIMEOUT, 255, idle cycles an owner may hold the bus without a strobe (1..2^16-1)

Ports (N = 0, 1 for each master):
- clk  in  1  register-bus clock
- reset_n  in  1  asynchronous, active-low reset
- mN_req  in  1  bus request; held high for the whole burst
- mN_gnt  out  1  grant; master may strobe only while high
- mN_addr  in  ADDR_W  register address
- mN_bytecnt  in  BCNT_W  byte index within burst
- mN_wdata  in  8  write data
- mN_read  in  1  read strobe, one byte per cycle
- mN_write  in  1  write strobe, one byte per cycle
- mN_rdata  out  8  read data
- mN_rvalid  out  1  mN_rdata valid, one-cycle pulse per read
- reg_address  out  ADDR_W  bus address
- reg_bytecnt  out  BCNT_W  bus byte count
- reg_datao  out  8  bus write data to slaves
- reg_datai  in  8  OR-ed read data from slaves
- reg_read  out  1  bus read strobe
- reg_write  out  1  bus write strobe
- reg_addrvalid  out  1  bus address valid
- owner_o  out  1  current/last owner index
- timeout_o  out  1  one-cycle pulse on forced release

## Operation
- FSM states: IDLE, OWN0, OWN1, TURN.
- IDLE: if exactly one mN_req high -> OWNN. Both high -> master != last_owner. None -> stay.
- OWNN: mN_gnt high. Owner's addr/bytecnt/wdata/read/write registered onto bus each cycle; reg_addrvalid = 1. Owner drops mN_req -> TURN.
- TURN: one cycle with gnt low, reg_addrvalid, reg_read, reg_write all 0; then same arbitration as IDLE (fairness vs. last_owner), else IDLE.
- Strobes from a non-granted master are ignored, never reach the bus.
- Read and write asserted together by owner: write forwarded, read dropped, no rvalid.
- Read return: reg_datai sampled the cycle after reg_read is high on the bus; presented on owner's mN_rdata with mN_rvalid. Return path tagged with the owner at strobe time, so a read in the owner's final cycle still returns to that master during TURN.
- Non-owner mN_rdata holds last value; mN_rvalid 0.
- Timeout: hold counter clears on every owner strobe and on entering OWNN, increments otherwise. Reaching TIMEOUT -> TURN, timeout_o pulse, and that master is locked out until its mN_req is seen low for at least one cycle.
- Counter saturates; no wrap.

## Timing
- Reset (async assert, sync deassert handled upstream): state IDLE, all gnt/strobes/addrvalid/rvalid/timeout_o 0, reg_address/bytecnt/datao 0, mN_rdata 0, owner_o 0, last_owner 1 (so master 0 wins the first tie).
- Reset mid-burst: bus strobes drop immediately; in-flight read return discarded.
- Request -> grant: mN_gnt high one edge after mN_req sampled high in IDLE/TURN.
- Master strobe -> bus strobe: 1 cycle. Master read -> mN_rvalid: 2 cycles.
- Release: mN_req low at edge k -> gnt low after k; other master earliest gnt after k+1.
- Back-to-back strobes sustained at one byte per cycle.

## Structure
- Shared package: state encoding, ADDR_W/BCNT_W defaults, master index constants.
- Single sub-module natural: `reg_bus_rr_pick` (2-way round-robin select from req vector, last_owner, lockout mask).

## Test plan
- Single master: m0 req, write addr 0x05 bytes 0xA1,0xA2 -> gnt after 1 cycle, reg_write two cycles with bytecnt 0,1, data A1,A2; release -> addrvalid 0 in TURN.
- Tie after reset: both req same cycle -> m0 granted; m0 releases -> one TURN cycle, then m1 granted; both re-request -> m0 next.
- Read path: m1 reads addr 0x2A, slave returns 0x5C -> m1_rvalid 2 cycles after m1_read, m1_rdata 0x5C, m0_rvalid stays 0.
- Final-cycle read: owner reads and drops req same cycle -> rvalid still to that owner during TURN.
- Timeout (TIMEOUT=4): m0 holds req with no strobes -> after 4 idle cycles gnt drops, timeout_o pulse, m1 granted; m0 re-granted only after dropping req.
- Non-owner and read+write: m1 strobes while m0 owns -> bus unchanged; owner asserts read+write -> only reg_write, no rvalid.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// reg_bus_arbiter_pkg
//   Shared definitions for the two-master register-bus arbiter.
//   - Arbiter FSM state encoding.
//   - Default bus widths.
//   - Master index constants.
//   - Small helper functions used by the arbiter.
package reg_bus_arbiter_pkg;

    localparam int DATA_W     = 8;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_BCNT_W = 16;
    localparam int CNT_W      = 16;   // hold counter width, covers TIMEOUT up to 2^16-1

    localparam logic M0 = 1'b0;       // USB host interface path
    localparam logic M1 = 1'b1;       // on-FPGA sequencer

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    // Saturating increment: the hold counter must never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic state_e own_state(input logic idx);
        return idx ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if
//   Bundles both master request ports and the shared slave-side register bus.
//   Modports:
//     slave  : view of the arbiter (serves the masters, drives the reg_* bus)
//     master : view of the masters and slave blocks around the arbiter
//   Per master N (0,1): mN_req/addr/bytecnt/wdata/read/write towards the
//   arbiter, mN_gnt/rdata/rvalid back. Bus: reg_address/bytecnt/datao/read/
//   write/addrvalid out of the arbiter, reg_datai (OR-ed slave data) in.
interface reg_bus_arbiter_if #(
    parameter int ADDR_W = reg_bus_arbiter_pkg::DEF_ADDR_W,
    parameter int BCNT_W = reg_bus_arbiter_pkg::DEF_BCNT_W
) ();
    import reg_bus_arbiter_pkg::*;

    logic              m0_req;
    logic              m0_gnt;
    logic [ADDR_W-1:0] m0_addr;
    logic [BCNT_W-1:0] m0_bytecnt;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rvalid;

    logic              m1_req;
    logic              m1_gnt;
    logic [ADDR_W-1:0] m1_addr;
    logic [BCNT_W-1:0] m1_bytecnt;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rvalid;

    logic [ADDR_W-1:0] reg_address;
    logic [BCNT_W-1:0] reg_bytecnt;
    logic [DATA_W-1:0] reg_datao;
    logic [DATA_W-1:0] reg_datai;
    logic              reg_read;
    logic              reg_write;
    logic              reg_addrvalid;

    modport slave (
        input  m0_req, m0_addr, m0_bytecnt, m0_wdata, m0_read, m0_write,
        output m0_gnt, m0_rdata, m0_rvalid,
        input  m1_req, m1_addr, m1_bytecnt, m1_wdata, m1_read, m1_write,
        output m1_gnt, m1_rdata, m1_rvalid,
        output reg_address, reg_bytecnt, reg_datao, reg_read, reg_write, reg_addrvalid,
        input  reg_datai
    );

    modport master (
        output m0_req, m0_addr, m0_bytecnt, m0_wdata, m0_read, m0_write,
        input  m0_gnt, m0_rdata, m0_rvalid,
        output m1_req, m1_addr, m1_bytecnt, m1_wdata, m1_read, m1_write,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  reg_address, reg_bytecnt, reg_datao, reg_read, reg_write, reg_addrvalid,
        output reg_datai
    );

endinterface

// File: rtl/reg_bus_arbiter_rr_pick.sv
// reg_bus_rr_pick
//   Two-way round-robin selector.
//   Ports:
//     req_i  : request vector, bit N = master N
//     mask_i : lockout vector, a set bit removes that master from the pick
//     last_i : index of the master that owned the bus most recently
//     vld_o  : at least one eligible request
//     idx_o  : chosen master (meaningful only when vld_o is high)
module reg_bus_rr_pick
    import reg_bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       last_i,
    output logic       vld_o,
    output logic       idx_o
);

    logic [1:0] elig;

    assign elig  = req_i & ~mask_i;
    assign vld_o = |elig;

    // On a tie the master that did not own the bus last wins.
    always_comb begin
        case (elig)
            2'b01:   idx_o = M0;
            2'b10:   idx_o = M1;
            default: idx_o = ~last_i;
        endcase
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Grants the shared 8-bit register bus to one of two masters per burst with
//   round-robin fairness, registers the owner's drive onto the bus, routes the
//   read data back to the master that issued the read, and forcibly releases
//   the bus from an owner that holds it without strobing for TIMEOUT cycles.
//   Ports:
//     clk       : register-bus clock
//     reset_n   : asynchronous active-low reset
//     bus       : master request ports + shared reg_* bus (slave modport)
//     owner_o   : current / most recent owner index
//     timeout_o : one-cycle pulse when an owner is forced off the bus
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BCNT_W  = DEF_BCNT_W,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    reg_bus_arbiter_if.slave bus,
    output logic             owner_o,
    output logic             timeout_o
);

    // Timeout fires when the counter already holds TIMEOUT-1 and this cycle
    // is idle again, i.e. after exactly TIMEOUT strobe-free cycles of ownership.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        req, rd, wr;
    logic [ADDR_W-1:0] m_addr  [2];
    logic [BCNT_W-1:0] m_bcnt  [2];
    logic [DATA_W-1:0] m_wdata [2];

    assign req        = {bus.m1_req,   bus.m0_req};
    assign rd         = {bus.m1_read,  bus.m0_read};
    assign wr         = {bus.m1_write, bus.m0_write};
    assign m_addr[0]  = bus.m0_addr;
    assign m_addr[1]  = bus.m1_addr;
    assign m_bcnt[0]  = bus.m0_bytecnt;
    assign m_bcnt[1]  = bus.m1_bytecnt;
    assign m_wdata[0] = bus.m0_wdata;
    assign m_wdata[1] = bus.m1_wdata;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [1:0]        lock_q, lock_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic [1:0]        gnt_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [DATA_W-1:0] datao_q, datao_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              av_q, av_d;
    logic              tag_q, tag_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [1:0]        rvalid_q;

    logic pick_vld, pick_idx;
    logic cur, fwd, arb;

    reg_bus_rr_pick u_pick (
        .req_i  (req),
        .mask_i (lock_q),
        .last_i (last_q),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        lock_d  = lock_q & req;   // a lockout ends once that request is seen low
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        addr_d  = addr_q;
        bcnt_d  = bcnt_q;
        datao_d = datao_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        av_d    = 1'b0;
        tag_d   = tag_q;
        cur     = owner_q;
        fwd     = 1'b0;
        arb     = 1'b0;

        case (state_q)
            ST_IDLE, ST_TURN: arb = 1'b1;
            ST_OWN0, ST_OWN1: begin
                cur = (state_q == ST_OWN1);
                if (!req[cur]) begin
                    state_d = ST_TURN;
                end else if (!(rd[cur] | wr[cur]) && cnt_q >= TO_LAST) begin
                    state_d     = ST_TURN;
                    tmo_d       = 1'b1;
                    lock_d[cur] = 1'b1;
                end else begin
                    fwd   = 1'b1;
                    cnt_d = (rd[cur] | wr[cur]) ? '0 : sat_inc(cnt_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (arb && pick_vld) begin
            state_d = own_state(pick_idx);
            owner_d = pick_idx;
            last_d  = pick_idx;
            cnt_d   = '0;
            cur     = pick_idx;
        end

        // The owner's address/data follow it every owned cycle; strobes only
        // once it actually holds the grant. Write wins over a simultaneous read.
        if (fwd || (arb && pick_vld)) begin
            addr_d  = m_addr[cur];
            bcnt_d  = m_bcnt[cur];
            datao_d = m_wdata[cur];
            av_d    = 1'b1;
        end
        if (fwd) begin
            wr_d = wr[cur];
            rd_d = rd[cur] & ~wr[cur];
            if (rd_d) tag_d = cur;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= M0;
            last_q     <= M1;
            lock_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            gnt_q      <= '0;
            addr_q     <= '0;
            bcnt_q     <= '0;
            datao_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            av_q       <= 1'b0;
            tag_q      <= M0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            gnt_q    <= {state_d == ST_OWN1, state_d == ST_OWN0};
            addr_q   <= addr_d;
            bcnt_q   <= bcnt_d;
            datao_q  <= datao_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            av_q     <= av_d;
            tag_q    <= tag_d;
            rvalid_q <= '0;
            // Slave data is sampled the cycle after reg_read was on the bus and
            // returned to the master tagged at strobe time, even if it has
            // since released the bus.
            if (rd_q) begin
                rdata_q[tag_q]  <= bus.reg_datai;
                rvalid_q[tag_q] <= 1'b1;
            end
        end
    end

    assign bus.m0_gnt        = gnt_q[0];
    assign bus.m1_gnt        = gnt_q[1];
    assign bus.m0_rdata      = rdata_q[0];
    assign bus.m1_rdata      = rdata_q[1];
    assign bus.m0_rvalid     = rvalid_q[0];
    assign bus.m1_rvalid     = rvalid_q[1];
    assign bus.reg_address   = addr_q;
    assign bus.reg_bytecnt   = bcnt_q;
    assign bus.reg_datao     = datao_q;
    assign bus.reg_read      = rd_q;
    assign bus.reg_write     = wr_q;
    assign bus.reg_addrvalid = av_q;
    assign owner_o           = owner_q;
    assign timeout_o         = tmo_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter
//   Directed bench for reg_bus_arbiter with TIMEOUT = 4. Inputs change 1 time
//   unit after each rising edge; outputs are checked at that same point.
module tb_reg_bus_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    logic owner_o, timeout_o;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.ADDR_W(6), .BCNT_W(16)) bif ();

    reg_bus_arbiter #(.ADDR_W(6), .BCNT_W(16), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bif),
        .owner_o   (owner_o),
        .timeout_o (timeout_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        bif.m0_req = 0; bif.m0_addr = '0; bif.m0_bytecnt = '0; bif.m0_wdata = '0;
        bif.m0_read = 0; bif.m0_write = 0;
        bif.m1_req = 0; bif.m1_addr = '0; bif.m1_bytecnt = '0; bif.m1_wdata = '0;
        bif.m1_read = 0; bif.m1_write = 0;
        bif.reg_datai = '0;
        #3;
        chk("rst_gnt0",    bif.m0_gnt, 0);
        chk("rst_gnt1",    bif.m1_gnt, 0);
        chk("rst_write",   bif.reg_write, 0);
        chk("rst_av",      bif.reg_addrvalid, 0);
        chk("rst_addr",    bif.reg_address, 0);
        chk("rst_owner",   owner_o, 0);
        chk("rst_rdata0",  bif.m0_rdata, 0);
        chk("rst_timeout", timeout_o, 0);
        step(); step();
        reset_n = 1'b1;

        // Single master write burst
        bif.m0_req = 1; step();
        chk("t1_gnt0", bif.m0_gnt, 1);
        chk("t1_gnt1", bif.m1_gnt, 0);
        chk("t1_av",   bif.reg_addrvalid, 1);
        chk("t1_nowr", bif.reg_write, 0);
        bif.m0_addr = 6'h05; bif.m0_bytecnt = 16'd0; bif.m0_wdata = 8'hA1; bif.m0_write = 1;
        step();
        chk("t1_wr0",  bif.reg_write, 1);
        chk("t1_addr", bif.reg_address, 8'h05);
        chk("t1_bc0",  bif.reg_bytecnt, 0);
        chk("t1_d0",   bif.reg_datao, 8'hA1);
        bif.m0_bytecnt = 16'd1; bif.m0_wdata = 8'hA2;
        step();
        chk("t1_wr1",  bif.reg_write, 1);
        chk("t1_bc1",  bif.reg_bytecnt, 1);
        chk("t1_d1",   bif.reg_datao, 8'hA2);
        bif.m0_write = 0; bif.m0_req = 0;
        step();
        chk("t1_turn_gnt", bif.m0_gnt, 0);
        chk("t1_turn_av",  bif.reg_addrvalid, 0);
        chk("t1_turn_wr",  bif.reg_write, 0);
        step();

        // Tie after reset, fairness
        reset_n = 1'b0; #1; reset_n = 1'b1;
        bif.m0_req = 1; bif.m1_req = 1; step();
        chk("t2_tie_gnt0", bif.m0_gnt, 1);
        chk("t2_tie_gnt1", bif.m1_gnt, 0);
        bif.m0_req = 0; step();
        chk("t2_turn_gnt0", bif.m0_gnt, 0);
        chk("t2_turn_gnt1", bif.m1_gnt, 0);
        step();
        chk("t2_gnt1",  bif.m1_gnt, 1);
        chk("t2_owner", owner_o, 1);
        bif.m1_req = 0; bif.m0_req = 1; step();
        chk("t2_turn2_gnt1", bif.m1_gnt, 0);
        bif.m1_req = 1; step();
        chk("t2_rr_gnt0", bif.m0_gnt, 1);
        chk("t2_rr_gnt1", bif.m1_gnt, 0);
        bif.m0_req = 0; bif.m1_req = 0; step(); step();

        // Read path on master 1
        bif.m1_req = 1; step();
        chk("t3_gnt1", bif.m1_gnt, 1);
        bif.m1_addr = 6'h2A; bif.m1_read = 1; step();
        chk("t3_bus_rd", bif.reg_read, 1);
        chk("t3_addr",   bif.reg_address, 8'h2A);
        chk("t3_rv_early", bif.m1_rvalid, 0);
        bif.m1_read = 0; bif.reg_datai = 8'h5C; step();
        chk("t3_rvalid", bif.m1_rvalid, 1);
        chk("t3_rdata",  bif.m1_rdata, 8'h5C);
        chk("t3_m0rv",   bif.m0_rvalid, 0);
        bif.reg_datai = 8'h00; step();
        chk("t3_rv_pulse", bif.m1_rvalid, 0);

        // Read in the owner's final cycle
        bif.m1_addr = 6'h11; bif.m1_read = 1; step();
        chk("t4_bus_rd", bif.reg_read, 1);
        bif.m1_read = 0; bif.m1_req = 0; bif.reg_datai = 8'h3E; step();
        chk("t4_gnt1",  bif.m1_gnt, 0);
        chk("t4_av",    bif.reg_addrvalid, 0);
        chk("t4_rd",    bif.reg_read, 0);
        chk("t4_rv",    bif.m1_rvalid, 1);
        chk("t4_rdata", bif.m1_rdata, 8'h3E);
        bif.reg_datai = 8'h00; step();
        chk("t4_rv_end",  bif.m1_rvalid, 0);
        chk("t4_m0rdata", bif.m0_rdata, 0);

        // Hold timeout and lockout
        bif.m0_req = 1; bif.m1_req = 1; step();
        chk("t5_gnt0", bif.m0_gnt, 1);
        step(); step(); step();
        chk("t5_hold_gnt0", bif.m0_gnt, 1);
        chk("t5_hold_tmo",  timeout_o, 0);
        step();
        chk("t5_tmo_gnt0", bif.m0_gnt, 0);
        chk("t5_tmo",      timeout_o, 1);
        chk("t5_tmo_gnt1", bif.m1_gnt, 0);
        step();
        chk("t5_gnt1",    bif.m1_gnt, 1);
        chk("t5_tmo_end", timeout_o, 0);
        chk("t5_owner",   owner_o, 1);
        bif.m1_req = 0; step();
        step();
        chk("t5_lock_a", bif.m0_gnt, 0);
        step();
        chk("t5_lock_b", bif.m0_gnt, 0);
        bif.m0_req = 0; step();
        bif.m0_req = 1; step();
        chk("t5_regnt0", bif.m0_gnt, 1);
        bif.m0_req = 0; step(); step();

        // Non-owner strobes, read+write from owner, reset mid-burst
        bif.m0_req = 1; step();
        bif.m0_addr = 6'h07; bif.m0_bytecnt = 16'd3; bif.m0_wdata = 8'h11;
        bif.m1_addr = 6'h3F; bif.m1_wdata = 8'hEE; bif.m1_write = 1; bif.m1_read = 1;
        step();
        chk("t6_nonown_wr", bif.reg_write, 0);
        chk("t6_nonown_rd", bif.reg_read, 0);
        chk("t6_addr",      bif.reg_address, 8'h07);
        chk("t6_datao",     bif.reg_datao, 8'h11);
        chk("t6_av",        bif.reg_addrvalid, 1);
        bif.m1_write = 0; bif.m1_read = 0;
        bif.m0_read = 1; bif.m0_write = 1; bif.m0_wdata = 8'h22; bif.reg_datai = 8'h99;
        step();
        chk("t6_rw_wr", bif.reg_write, 1);
        chk("t6_rw_rd", bif.reg_read, 0);
        chk("t6_rw_d",  bif.reg_datao, 8'h22);
        bif.m0_read = 0; step();
        chk("t6_rv0",     bif.m0_rvalid, 0);
        chk("t6_rv1",     bif.m1_rvalid, 0);
        chk("t6_m1hold",  bif.m1_rdata, 8'h3E);
        chk("t6_wr_again", bif.reg_write, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_wr",   bif.reg_write, 0);
        chk("t6_rst_gnt0", bif.m0_gnt, 0);
        chk("t6_rst_av",   bif.reg_addrvalid, 0);
        bif.m0_write = 0; bif.m0_req = 0; bif.reg_datai = 8'h00;
        #5 reset_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
